bnn_acc_relu_array: RTL



---
 rtl/bnn_pkg.sv | 34 +++
 rtl/bnn_acc_relu_array_if.sv | 47 ++++
 rtl/bnn_sat_lane.sv | 36 +++
 rtl/bnn_acc_relu_array.sv | 132 +++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared definitions for the bnn_acc_relu_array accumulate-and-activate block.
// Holds the FSM and op encodings, the default widths, and a small helper
// used for the saturating beat counter.
package bnn_pkg;

    // FSM state encoding, kept as plain constants for legacy tools
    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    // Per-beat operation applied to every lane
    localparam logic [0:0] OP_ADD = 1'b0;
    localparam logic [0:0] OP_SUB = 1'b1;

    // Default geometry of the array
    localparam int LANES_DEF = 4;
    localparam int ACC_W_DEF = 12;
    localparam int CNT_W_DEF = 10;

    // Widest counter the helper below supports
    localparam int CNT_W_MAX = 32;

    // Increment that sticks at all-ones instead of wrapping back to zero
    function automatic logic [CNT_W_MAX-1:0] sat_inc(input logic [CNT_W_MAX-1:0] value,
                                                     input logic [CNT_W_MAX-1:0] max_value);
        logic [CNT_W_MAX-1:0] result;
        if (value >= max_value) begin
            result = max_value;
        end else begin
            result = value + 1'b1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bnn_acc_relu_array_if.sv
// Stream interface of the bnn_acc_relu_array block: the input beat channel
// (valid/ready with per-lane bits, op and last) and the result channel
// (valid/ready with packed ReLU data and beat count).
// The master modport is the upstream/downstream environment, the slave
// modport is the accumulator block itself.
interface bnn_acc_relu_array_if #(
    parameter int LANES = 4,
    parameter int ACC_W = 12,
    parameter int CNT_W = 10
);

    logic                   in_valid;
    logic                   in_ready;
    logic [LANES-1:0]       in_bits;
    logic [0:0]             in_op;
    logic                   in_last;

    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*ACC_W-1:0] out_data;
    logic [CNT_W-1:0]       out_cnt;

    modport master (
        output in_valid,
        input  in_ready,
        output in_bits,
        output in_op,
        output in_last,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_cnt
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_bits,
        input  in_op,
        input  in_last,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_cnt
    );

endinterface

// File: rtl/bnn_sat_lane.sv
// One accumulator lane: adds or subtracts a single bit to the signed
// accumulator with clamping at the two's complement limits, and provides
// the ReLU of that clamped result for the output register.
module bnn_sat_lane
    import bnn_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0] acc_i,
    input  logic             bit_i,
    input  logic [0:0]       op_i,
    output logic [ACC_W-1:0] sum_o,
    output logic [ACC_W-1:0] relu_o
);

    localparam logic [ACC_W-1:0] MAX_VAL = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] MIN_VAL = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W:0] delta;
    logic [ACC_W:0] wide_sum;

    // One guard bit catches overflow; a disagreeing guard and sign bit selects the clamp
    always_comb begin
        delta = '0;
        if (bit_i) begin
            delta = (op_i == OP_SUB) ? {(ACC_W+1){1'b1}} : {{ACC_W{1'b0}}, 1'b1};
        end
        wide_sum = {acc_i[ACC_W-1], acc_i} + delta;
        sum_o    = wide_sum[ACC_W-1:0];
        if (wide_sum[ACC_W] != wide_sum[ACC_W-1]) begin
            sum_o = wide_sum[ACC_W] ? MIN_VAL : MAX_VAL;
        end
        relu_o = sum_o[ACC_W-1] ? '0 : sum_o;
    end

endmodule

// File: rtl/bnn_acc_relu_array.sv
// Multi-lane accumulate-and-activate unit. Each lane accumulates +/-1 terms
// per accepted beat; the beat flagged last latches the ReLU of every lane
// plus the beat count into a held output until the downstream takes it.
// Optional build macro: ACC_BIAS_EN adds a per-lane bias port that is used as
// the accumulator start value at every reload (soft clear or output handshake).
module bnn_acc_relu_array
    import bnn_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
`ifdef ACC_BIAS_EN
    input  logic [LANES*ACC_W-1:0] bias,
`endif
    bnn_acc_relu_array_if.slave    bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [0:0]             state_q;
    logic [0:0]             state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic [CNT_W-1:0]       cnt_inc;
    logic [ACC_W-1:0]       acc_q     [LANES];
    logic [ACC_W-1:0]       acc_d     [LANES];
    logic [ACC_W-1:0]       lane_sum  [LANES];
    logic [ACC_W-1:0]       lane_relu [LANES];
    logic [ACC_W-1:0]       start_val [LANES];
    logic [LANES*ACC_W-1:0] out_data_q;
    logic [LANES*ACC_W-1:0] out_data_d;
    logic [CNT_W-1:0]       out_cnt_q;
    logic [CNT_W-1:0]       out_cnt_d;
    logic [CNT_W_MAX-1:0]   cnt_inc_wide;
    logic                   beat_xfer;
    logic                   out_xfer;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        bnn_sat_lane #(
            .ACC_W (ACC_W)
        ) u_lane (
            .acc_i  (acc_q[g]),
            .bit_i  (bus.in_bits[g]),
            .op_i   (bus.in_op),
            .sum_o  (lane_sum[g]),
            .relu_o (lane_relu[g])
        );

`ifdef ACC_BIAS_EN
        assign start_val[g] = bias[g*ACC_W +: ACC_W];
`else
        assign start_val[g] = '0;
`endif
    end

    assign beat_xfer = bus.in_valid && (state_q == ST_ACCUM);
    assign out_xfer  = (state_q == ST_HOLD) && bus.out_ready;

    // Counter increment that sticks at its maximum, widened through the package helper
    always_comb begin
        cnt_inc_wide = sat_inc(CNT_W_MAX'(cnt_q), CNT_W_MAX'(CNT_MAX));
        cnt_inc      = cnt_inc_wide[CNT_W-1:0];
    end

    // Next-state logic: soft clear wins, then beat accumulation, then output release
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        out_cnt_d  = out_cnt_q;
        for (int i = 0; i < LANES; i++) begin
            acc_d[i] = acc_q[i];
        end

        if (clr) begin
            state_d = ST_ACCUM;
            cnt_d   = '0;
            for (int i = 0; i < LANES; i++) begin
                acc_d[i] = start_val[i];
            end
        end else if (beat_xfer) begin
            cnt_d = cnt_inc;
            for (int i = 0; i < LANES; i++) begin
                acc_d[i] = lane_sum[i];
            end
            if (bus.in_last) begin
                state_d   = ST_HOLD;
                out_cnt_d = cnt_inc;
                for (int i = 0; i < LANES; i++) begin
                    out_data_d[i*ACC_W +: ACC_W] = lane_relu[i];
                end
            end
        end else if (out_xfer) begin
            state_d = ST_ACCUM;
            cnt_d   = '0;
            for (int i = 0; i < LANES; i++) begin
                acc_d[i] = start_val[i];
            end
        end
    end

    // State, counter, lane accumulators and the held result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ACCUM;
            cnt_q      <= '0;
            out_data_q <= '0;
            out_cnt_q  <= '0;
            for (int i = 0; i < LANES; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
            out_cnt_q  <= out_cnt_d;
            for (int i = 0; i < LANES; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

    assign bus.in_ready  = (state_q == ST_ACCUM);
    assign bus.out_valid = (state_q == ST_HOLD);
    assign bus.out_data  = out_data_q;
    assign bus.out_cnt   = out_cnt_q;

endmodule
